// File: rtl/fifo_rd_ctrl_if.sv
// Read-side port bundle of the async FIFO: consumer request/flush controls,
// synchronised write pointer in, memory read address/enable and status out.
interface fifo_rd_ctrl_if #(
    parameter int unsigned ADDRESS_WIDTH = 3
);
    logic                     R_INC;
    logic                     FLUSH;
    logic                     CLR_ERR;
    logic [ADDRESS_WIDTH:0]   W_PTR;
    logic [ADDRESS_WIDTH-1:0] R_ADDR;
    logic                     R_EN;
    logic [ADDRESS_WIDTH:0]   R_PTR;
    logic                     EMPTY;
    logic                     ALMOST_EMPTY;
    logic [ADDRESS_WIDTH:0]   LEVEL;
    logic                     UNDERFLOW;

    // master: the consumer/synchroniser side; slave: the read controller
    modport master (
        output R_INC, FLUSH, CLR_ERR, W_PTR,
        input  R_ADDR, R_EN, R_PTR, EMPTY, ALMOST_EMPTY, LEVEL, UNDERFLOW
    );
    modport slave (
        input  R_INC, FLUSH, CLR_ERR, W_PTR,
        output R_ADDR, R_EN, R_PTR, EMPTY, ALMOST_EMPTY, LEVEL, UNDERFLOW
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side pointer controller: binary read counter, Gray/binary
// outgoing pointer, empty/level/almost-empty status, flush and sticky underflow.
module fifo_rd_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 3,
    parameter int unsigned AEMPTY_THRESH = 1,
    parameter bit          GRAY_PTR      = 1'b1
) (
    input logic           R_CLK,
    input logic           R_RST,
    fifo_rd_ctrl_if.slave bus
);
    localparam int unsigned PW = ADDRESS_WIDTH + 1;
    localparam logic [PW-1:0] AeThresh = PW'(AEMPTY_THRESH);

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic          underflow_q, underflow_d;
    logic [PW-1:0] wbin_gray;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level;
    logic          empty;

    // Gray-to-binary: bit i is the XOR of all Gray bits at or above i
    always_comb begin
        wbin_gray = '0;
        for (int i = 0; i < PW; i++) begin
            wbin_gray[i] = ^(bus.W_PTR >> i);
        end
    end

    assign wbin  = GRAY_PTR ? wbin_gray : bus.W_PTR;
    assign empty = (wbin == rbin_q);
    assign level = wbin - rbin_q;

    always_comb begin
        rbin_d      = rbin_q;
        underflow_d = underflow_q;
        if (bus.FLUSH) begin
            rbin_d = wbin;
        end else if (bus.R_INC && !empty) begin
            rbin_d = rbin_q + PW'(1);
        end
        if (bus.CLR_ERR) begin
            underflow_d = 1'b0;
        end
        // Set is applied after clear so a coincident set wins
        if (bus.R_INC && empty && !bus.FLUSH) begin
            underflow_d = 1'b1;
        end
        r_ptr_d = GRAY_PTR ? (rbin_d ^ (rbin_d >> 1)) : rbin_d;
    end

    always_ff @(posedge R_CLK) begin
        if (R_RST) begin
            rbin_q      <= '0;
            r_ptr_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rbin_q      <= rbin_d;
            r_ptr_q     <= r_ptr_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.R_ADDR       = rbin_q[ADDRESS_WIDTH-1:0];
    assign bus.R_EN         = bus.R_INC & ~empty;
    assign bus.R_PTR        = r_ptr_q;
    assign bus.EMPTY        = empty;
    assign bus.LEVEL        = level;
    assign bus.ALMOST_EMPTY = (level <= AeThresh);
    assign bus.UNDERFLOW    = underflow_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (ADDRESS_WIDTH=3, GRAY_PTR=1, AEMPTY_THRESH=1).
module tb_fifo_rd_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.ADDRESS_WIDTH(3)) bus ();

    fifo_rd_ctrl #(
        .ADDRESS_WIDTH(3),
        .AEMPTY_THRESH(1),
        .GRAY_PTR     (1'b1)
    ) dut (
        .R_CLK(clk),
        .R_RST(rst),
        .bus  (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        rst         = 1'b1;
        bus.R_INC   = 1'b0;
        bus.FLUSH   = 1'b0;
        bus.CLR_ERR = 1'b0;
        bus.W_PTR   = 4'b0000;

        // 1. Reset
        tick();
        tick();
        check_val("rst_r_ptr", 32'(bus.R_PTR), 32'd0);
        check_val("rst_r_addr", 32'(bus.R_ADDR), 32'd0);
        check_val("rst_empty", 32'(bus.EMPTY), 32'd1);
        check_val("rst_level", 32'(bus.LEVEL), 32'd0);
        check_val("rst_aempty", 32'(bus.ALMOST_EMPTY), 32'd1);
        check_val("rst_underflow", 32'(bus.UNDERFLOW), 32'd0);
        rst = 1'b0;

        // 2. Drain five entries
        bus.W_PTR = 4'b0111;
        settle();
        check_val("drain_level5", 32'(bus.LEVEL), 32'd5);
        check_val("drain_not_empty", 32'(bus.EMPTY), 32'd0);
        check_val("drain_not_aempty", 32'(bus.ALMOST_EMPTY), 32'd0);
        bus.R_INC = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_val("drain_r_addr", 32'(bus.R_ADDR), 32'(i));
            check_val("drain_r_en", 32'(bus.R_EN), 32'd1);
            tick();
        end
        bus.R_INC = 1'b0;
        settle();
        check_val("drain_r_addr4", 32'(bus.R_ADDR), 32'd4);
        check_val("drain_level1", 32'(bus.LEVEL), 32'd1);
        check_val("drain_aempty1", 32'(bus.ALMOST_EMPTY), 32'd1);
        check_val("drain_empty1", 32'(bus.EMPTY), 32'd0);
        bus.R_INC = 1'b1;
        tick();
        bus.R_INC = 1'b0;
        settle();
        check_val("drain_empty", 32'(bus.EMPTY), 32'd1);
        check_val("drain_r_ptr", 32'(bus.R_PTR), 32'b0111);
        check_val("drain_level0", 32'(bus.LEVEL), 32'd0);

        // 3. Underflow set, persist, clear, set-wins
        bus.R_INC = 1'b1;
        settle();
        check_val("uf_r_en", 32'(bus.R_EN), 32'd0);
        tick();
        bus.R_INC = 1'b0;
        settle();
        check_val("uf_set", 32'(bus.UNDERFLOW), 32'd1);
        check_val("uf_r_addr_hold", 32'(bus.R_ADDR), 32'd5);
        check_val("uf_r_ptr_hold", 32'(bus.R_PTR), 32'b0111);
        tick();
        check_val("uf_persist", 32'(bus.UNDERFLOW), 32'd1);
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;
        settle();
        check_val("uf_cleared", 32'(bus.UNDERFLOW), 32'd0);
        bus.R_INC   = 1'b1;
        bus.CLR_ERR = 1'b1;
        tick();
        bus.R_INC   = 1'b0;
        bus.CLR_ERR = 1'b0;
        settle();
        check_val("uf_set_wins", 32'(bus.UNDERFLOW), 32'd1);
        bus.CLR_ERR = 1'b1;
        tick();
        bus.CLR_ERR = 1'b0;

        // 4. Full and wrap
        rst       = 1'b1;
        bus.W_PTR = 4'b0000;
        tick();
        rst       = 1'b0;
        bus.W_PTR = 4'b1100;
        settle();
        check_val("full_level8", 32'(bus.LEVEL), 32'd8);
        check_val("full_not_empty", 32'(bus.EMPTY), 32'd0);
        check_val("full_not_aempty", 32'(bus.ALMOST_EMPTY), 32'd0);
        bus.R_INC = 1'b1;
        for (int i = 0; i < 8; i++) begin
            settle();
            check_val("full_r_addr", 32'(bus.R_ADDR), 32'(i));
            tick();
        end
        bus.R_INC = 1'b0;
        settle();
        check_val("full_r_addr_wrap", 32'(bus.R_ADDR), 32'd0);
        check_val("full_r_ptr8", 32'(bus.R_PTR), 32'b1100);
        check_val("full_empty", 32'(bus.EMPTY), 32'd1);
        bus.W_PTR = 4'b0000;
        settle();
        check_val("wrap_level8", 32'(bus.LEVEL), 32'd8);
        bus.R_INC = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        bus.R_INC = 1'b0;
        settle();
        check_val("wrap_r_ptr15", 32'(bus.R_PTR), 32'b1000);
        check_val("wrap_level1", 32'(bus.LEVEL), 32'd1);
        check_val("wrap_r_addr7", 32'(bus.R_ADDR), 32'd7);
        bus.R_INC = 1'b1;
        tick();
        bus.R_INC = 1'b0;
        settle();
        check_val("wrap_r_ptr0", 32'(bus.R_PTR), 32'b0000);
        check_val("wrap_r_addr0", 32'(bus.R_ADDR), 32'd0);
        check_val("wrap_empty", 32'(bus.EMPTY), 32'd1);

        // 5. Flush with concurrent read
        bus.W_PTR = to_gray(4'd6);
        settle();
        check_val("flush_level6", 32'(bus.LEVEL), 32'd6);
        bus.FLUSH = 1'b1;
        bus.R_INC = 1'b1;
        settle();
        check_val("flush_r_en", 32'(bus.R_EN), 32'd1);
        tick();
        bus.FLUSH = 1'b0;
        bus.R_INC = 1'b0;
        settle();
        check_val("flush_empty", 32'(bus.EMPTY), 32'd1);
        check_val("flush_level0", 32'(bus.LEVEL), 32'd0);
        check_val("flush_r_addr", 32'(bus.R_ADDR), 32'd6);
        check_val("flush_r_ptr", 32'(bus.R_PTR), 32'b0101);
        check_val("flush_uf", 32'(bus.UNDERFLOW), 32'd0);
        bus.FLUSH = 1'b1;
        bus.R_INC = 1'b1;
        tick();
        bus.FLUSH = 1'b0;
        bus.R_INC = 1'b0;
        settle();
        check_val("flush_empty_no_uf", 32'(bus.UNDERFLOW), 32'd0);

        // 6. Reset mid-drain, with underflow pending
        bus.R_INC = 1'b1;
        tick();
        bus.R_INC = 1'b0;
        settle();
        check_val("mid_uf_pre", 32'(bus.UNDERFLOW), 32'd1);
        bus.W_PTR = to_gray(4'd9);
        settle();
        check_val("mid_level3", 32'(bus.LEVEL), 32'd3);
        rst       = 1'b1;
        bus.R_INC = 1'b1;
        tick();
        rst       = 1'b0;
        bus.R_INC = 1'b0;
        settle();
        check_val("mid_r_ptr", 32'(bus.R_PTR), 32'd0);
        check_val("mid_r_addr", 32'(bus.R_ADDR), 32'd0);
        check_val("mid_uf", 32'(bus.UNDERFLOW), 32'd0);
        check_val("mid_level9", 32'(bus.LEVEL), 32'd9);
        check_val("mid_not_empty", 32'(bus.EMPTY), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Parametrised read-side pointer controller for the async FIFO, running entirely in the read clock domain. It consumes the write pointer, which is already synchronised into this domain. It produces the memory read address, the outgoing read pointer for synchronisation to the write domain, and status: EMPTY, fill level, almost-empty, sticky underflow. Compared with the previous read-side block it adds a configurable pointer encoding, fill-level reporting, a programmable almost-empty threshold, a synchronous flush and error capture.

Parameters:
ADDRESS_WIDTH, 3, memory address bits; DEPTH = 2**ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits.
AEMPTY_THRESH, 1, ALMOST_EMPTY asserts when LEVEL <= AEMPTY_THRESH; legal range 0..DEPTH.
GRAY_PTR, 1, 1 = R_PTR driven and W_PTR interpreted as Gray code (async use); 0 = both plain binary (same-clock use).

Ports:
R_CLK  input  1  read-domain clock; all state updates on its rising edge.
R_RST  input  1  synchronous, active-high reset, sampled on rising R_CLK.
R_INC  input  1  read request; pops one entry when not EMPTY.
FLUSH  input  1  synchronous flush; discards all visible entries.
CLR_ERR  input  1  clears UNDERFLOW.
W_PTR  input  ADDRESS_WIDTH+1  synchronised write pointer, encoding per GRAY_PTR.
R_ADDR  output  ADDRESS_WIDTH  memory read address = rbin[ADDRESS_WIDTH-1:0].
R_EN  output  1  memory read enable = R_INC & ~EMPTY (combinational).
R_PTR  output  ADDRESS_WIDTH+1  registered read pointer, encoding per GRAY_PTR.
EMPTY  output  1  FIFO empty.
ALMOST_EMPTY  output  1  LEVEL <= AEMPTY_THRESH.
LEVEL  output  ADDRESS_WIDTH+1  entries available, 0..DEPTH.
UNDERFLOW  output  1  sticky: a read was attempted while EMPTY.

Behaviour:
- State: rbin (ADDRESS_WIDTH+1 binary counter), R_PTR register, UNDERFLOW flop.
- Reset (R_RST=1 at edge): rbin=0, R_PTR=0, UNDERFLOW=0. R_RST has priority over all other inputs, including mid-operation. After reset, R_ADDR=0. EMPTY, LEVEL and ALMOST_EMPTY follow from W_PTR; with W_PTR=0: EMPTY=1, LEVEL=0, ALMOST_EMPTY=1.
- wbin = gray-to-binary(W_PTR) when GRAY_PTR=1, else W_PTR.
- Next-pointer priority: FLUSH → rbin_next = wbin. Else R_INC & ~EMPTY → rbin_next = rbin+1, modulo 2**(ADDRESS_WIDTH+1). Else hold.
- R_PTR <= encode(rbin_next) on the same edge as rbin updates. R_PTR and rbin are always consistent, with no one-cycle lag. Gray encode is b ^ (b>>1).
- EMPTY = (wbin == rbin), computed combinationally from flops and input.
- LEVEL = (wbin - rbin) mod 2**(ADDRESS_WIDTH+1). A value > DEPTH is a producer error and is not clamped.
- ALMOST_EMPTY = (LEVEL <= AEMPTY_THRESH); it includes EMPTY when AEMPTY_THRESH >= 0.
- UNDERFLOW: set on an edge where R_INC=1, EMPTY=1 and FLUSH=0. Cleared by CLR_ERR. If set and clear occur together, set wins. Otherwise holds.
- R_INC together with FLUSH: the flush wins, R_EN still follows its equation for that cycle, and no underflow is raised.
- Wrap-around: the extra MSB distinguishes full (LEVEL=DEPTH) from empty. R_ADDR wraps from DEPTH-1 to 0.
- Read data latency: one R_CLK after R_EN, for a synchronous memory. Not this block's concern beyond R_ADDR/R_EN timing.

Test Plan:
All cases use ADDRESS_WIDTH=3, GRAY_PTR=1, AEMPTY_THRESH=1.
1. Reset: R_RST=1 for 2 cycles, W_PTR=4'b0000 → R_PTR=0, R_ADDR=0, EMPTY=1, LEVEL=0, ALMOST_EMPTY=1, UNDERFLOW=0.
2. Drain: W_PTR=4'b0111 (binary 5) → LEVEL=5, EMPTY=0. Four R_INC pulses → R_ADDR steps 0,1,2,3,4, LEVEL=1, ALMOST_EMPTY=1. One more R_INC → EMPTY=1, R_PTR=4'b0111.
3. Underflow: with EMPTY=1, R_INC=1 for 1 cycle → rbin unchanged, R_EN=0, UNDERFLOW=1 from the next cycle. UNDERFLOW persists until CLR_ERR=1, then reads 0. Simultaneous set and clear → UNDERFLOW=1.
4. Full and wrap: rbin=0, W_PTR=4'b1100 (binary 8) → LEVEL=8, EMPTY=0. Eight reads → R_ADDR 7→0, rbin=8, R_PTR=4'b1100, EMPTY=1. Continue to rbin=15 → next read gives R_PTR=4'b0000, rbin=0.
5. Flush: LEVEL=6, assert FLUSH and R_INC together → next cycle rbin=wbin, EMPTY=1, LEVEL=0, UNDERFLOW unchanged.
6. Reset mid-drain: LEVEL=3, assert R_RST during R_INC → next cycle rbin=0, R_PTR=0, UNDERFLOW=0. LEVEL is recomputed from the current W_PTR.
